// File: rtl/dmem_ctrl.sv
// RV32I load/store unit: aligns stores onto a word-wide memory port, extracts
// and extends load data, and reports misaligned, illegal or timed-out accesses.
module dmem_ctrl #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err
);

    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] cnt;
    logic          we_q;
    logic [2:0]    funct3_q;
    logic [1:0]    off_q;
    logic [31:0]   rdata_q;
    logic          err_q;

    logic          accept;
    logic          misaligned;
    logic          illegal;
    logic          flagged;
    logic          timeout;
    logic [31:0]   shifted;
    logic [31:0]   load_data;

    always_comb begin
        misaligned = 1'b0;
        illegal    = 1'b0;
        case (req_funct3)
            3'b001, 3'b101: misaligned = req_addr[0];
            3'b010:         misaligned = (req_addr[1:0] != 2'b00);
            default:        misaligned = 1'b0;
        endcase
        if (req_we)
            illegal = !(req_funct3 inside {3'b000, 3'b001, 3'b010});
        else
            illegal = (req_funct3 inside {3'b011, 3'b110, 3'b111});
        flagged = misaligned || illegal;
    end

    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign timeout   = (state == WAIT) && !mem_ack && (cnt == CNT_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = flagged ? RESP : WAIT;
            WAIT:    if (mem_ack || timeout) next_state = RESP;
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            cnt       <= '0;
            we_q      <= 1'b0;
            funct3_q  <= '0;
            off_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    we_q     <= req_we;
                    funct3_q <= req_funct3;
                    off_q    <= req_addr[1:0];
                    cnt      <= '0;
                    err_q    <= flagged;
                    if (!flagged) begin
                        mem_req  <= 1'b1;
                        mem_we   <= req_we;
                        mem_addr <= {req_addr[31:2], 2'b00};
                        case (req_funct3[1:0])
                            2'b00: begin
                                mem_be    <= 4'b0001 << req_addr[1:0];
                                mem_wdata <= {4{req_wdata[7:0]}};
                            end
                            2'b01: begin
                                mem_be    <= 4'b0011 << req_addr[1:0];
                                mem_wdata <= {2{req_wdata[15:0]}};
                            end
                            default: begin
                                mem_be    <= 4'b1111;
                                mem_wdata <= req_wdata;
                            end
                        endcase
                    end
                end
                WAIT: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        rdata_q <= mem_rdata;
                    end else if (timeout) begin
                        mem_req <= 1'b0;
                        mem_we  <= 1'b0;
                        err_q   <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Response is driven from RESP state so it lasts exactly one cycle and is
    // zero whenever the block is idle or in reset.
    always_comb begin
        shifted = rdata_q >> {off_q, 3'b000};
        case (funct3_q)
            3'b000:  load_data = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_data = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_data = {24'h0, shifted[7:0]};
            3'b101:  load_data = {16'h0, shifted[15:0]};
            default: load_data = shifted;
        endcase
        rsp_valid = (state == RESP);
        rsp_err   = rsp_valid && err_q;
        rsp_data  = (rsp_valid && !err_q && !we_q) ? load_data : '0;
    end

endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL provide parameter TIMEOUT_CYCLES, 16, maximum cycles waiting for mem_ack before an error response.
REQ-002 SHALL provide port clk  in  1  sole clock, all state updates on the rising edge.
REQ-003 SHALL provide port rst_n  in  1  asynchronous, active-low reset.
REQ-004 SHALL provide port req_valid  in  1  execute stage presents a load/store.
REQ-005 SHALL provide port req_ready  out  1  block can accept a request.
REQ-006 SHALL provide port req_we  in  1  1 = store, 0 = load.
REQ-007 SHALL provide port req_funct3  in  3  RV32I load/store funct3.
REQ-008 SHALL provide port req_addr  in  32  effective byte address, base plus sign-extended imm, computed upstream.
REQ-009 SHALL provide port req_wdata  in  32  store data, right-aligned.
REQ-010 SHALL provide ports mem_req out 1, mem_we out 1, mem_addr out 32 (word-aligned), mem_wdata out 32, mem_be out 4  memory request side.
REQ-011 SHALL provide ports mem_ack in 1, mem_rdata in 32  memory completion side.
REQ-012 SHALL provide ports rsp_valid out 1, rsp_data out 32, rsp_err out 1  writeback side.

Function
REQ-013 SHALL implement FSM states IDLE, WAIT, RESP; req_ready = 1 only in IDLE.
REQ-014 SHALL accept a request when req_valid && req_ready, capturing we, funct3, addr, wdata.
REQ-015 SHALL flag misaligned: halfword (funct3 001/101) with addr[0]=1; word (010) with addr[1:0]!=0.
REQ-016 SHALL flag illegal: loads with funct3 011/110/111; stores with funct3 other than 000/001/010.
REQ-017 SHALL, on an accepted flagged request, go IDLE->RESP directly with no mem_req assertion.
REQ-018 SHALL, on an accepted legal request, go IDLE->WAIT with mem_req registered high from the next cycle.
REQ-019 SHALL drive mem_addr = {addr[31:2],2'b00}, held stable while mem_req is high.
REQ-020 SHALL drive mem_be: byte 4'b0001<<addr[1:0]; half 4'b0011<<addr[1:0]; word 4'b1111; loads use the same mask.
REQ-021 SHALL drive mem_wdata with byte replicated 4x for SB, half replicated 2x for SH, unchanged for SW.
REQ-022 SHALL, in WAIT with mem_ack=1, drop mem_req next cycle, register mem_rdata, and go to RESP.
REQ-023 SHALL extract load data by right-shifting the registered word by 8*addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW unchanged.
REQ-024 SHALL count cycles in WAIT; if count reaches TIMEOUT_CYCLES without mem_ack, drop mem_req and go to RESP with rsp_err=1.
REQ-025 SHALL, in RESP, assert rsp_valid for exactly one cycle, then return to IDLE.
REQ-026 SHALL drive rsp_data = 0 for stores and for every error response.
REQ-027 SHALL ignore mem_ack outside WAIT.
REQ-028 SHALL deliver minimum latency of acceptance in cycle N, mem_req in N+1, ack in N+1, rsp_valid in N+2.
REQ-029 SHALL accept a new request no earlier than the cycle after rsp_valid.

Reset
REQ-030 SHALL, on rst_n low, immediately enter IDLE and clear mem_req, mem_we, mem_be, rsp_valid, rsp_err, rsp_data, mem_addr, mem_wdata, and the timeout counter.
REQ-031 SHALL, on reset during WAIT, drop mem_req at once and discard the in-flight request with no response.
REQ-032 SHALL drive req_ready = 1 in the first cycle after rst_n deasserts.

Verification
REQ-033 SHALL cover LB addr 0x103, mem_rdata 0x80FF_1234 -> mem_be 4'b1000, rsp_data 0xFFFF_FF80, rsp_err 0.
REQ-034 SHALL cover LHU addr 0x102, mem_rdata 0xBEEF_0000 -> mem_be 4'b1100, rsp_data 0x0000_BEEF.
REQ-035 SHALL cover SB addr 0x201, wdata 0x0000_00AB -> mem_addr 0x200, mem_be 4'b0010, mem_wdata 0xABAB_ABAB, mem_we 1.
REQ-036 SHALL cover LW addr 0x102 -> no mem_req, rsp_valid one cycle after acceptance with rsp_err 1, rsp_data 0.
REQ-037 SHALL cover LW with mem_ack held low -> mem_req drops after 16 WAIT cycles, rsp_err 1.
REQ-038 SHALL cover rst_n low during WAIT -> mem_req 0 immediately, no rsp_valid, req_ready 1 after release.
